// File: rtl/bw_postfix_sequencer.sv
// Decode-stage instruction queue: groups each instruction with up to three CON postfixes,
// presents the group to the decoder under valid/ready, and drops orphan postfixes.
module bw_postfix_sequencer #(
  parameter int         IW      = 40,
  parameter int         DEPTH   = 8,
  parameter int         OPLSB   = 0,
  parameter logic [5:0] CON1_OP = 6'h3D,
  parameter logic [5:0] CON2_OP = 6'h3E,
  parameter logic [5:0] CON3_OP = 6'h3F
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       fi_valid_i,
  input  logic [IW-1:0]              fi_ir_i,
  output logic                       fi_ready_o,
  output logic                       dv_o,
  input  logic                       dr_i,
  output logic [IW-1:0]              ir_o,
  output logic [IW-1:0]              ir1_o,
  output logic [IW-1:0]              ir2_o,
  output logic [IW-1:0]              ir3_o,
  output logic [1:0]                 ncon_o,
  output logic [$clog2(DEPTH):0]     occ_o,
  output logic                       err_orphan_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          err_q;

  logic [IW-1:0] ent [4];
  logic [3:0]    present, con;
  logic [1:0]    ncon;
  logic          tail_ok, orphan, complete, push;
  logic [2:0]    pop_n;

  function automatic logic is_con(input logic [5:0] op);
    return (op == CON1_OP) || (op == CON2_OP) || (op == CON3_OP);
  endfunction

  // Window of the four entries starting at the head; con[k] is only set for present entries.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ent[k]     = mem[rd_ptr + PW'(k)];
      present[k] = count > CW'(k);
      con[k]     = present[k] && is_con(ent[k][OPLSB +: 6]);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ncon = 2'd0;
    if (con[1]) begin
      ncon = 2'd1;
      if (con[2]) begin
        ncon = 2'd2;
        if (con[3]) ncon = 2'd3;
      end
    end
    // The entry after the last postfix is either absent or a non-CON, so presence suffices.
    unique case (ncon)
      2'd0:    tail_ok = present[1];
      2'd1:    tail_ok = present[2];
      2'd2:    tail_ok = present[3];
      default: tail_ok = 1'b1;
    endcase
    orphan   = con[0];
    complete = present[0] && !con[0] && tail_ok;

    fi_ready_o = (count != CW'(DEPTH));
    push       = fi_valid_i && fi_ready_o && !flush_i;
    pop_n      = 3'd0;
    if (orphan)               pop_n = 3'd1;
    else if (complete && dr_i) pop_n = {1'b0, ncon} + 3'd1;
  end

  always_comb begin
    dv_o   = complete;
    ir_o   = complete               ? ent[0] : '0;
    ir1_o  = (complete && ncon > 0) ? ent[1] : '0;
    ir2_o  = (complete && ncon > 1) ? ent[2] : '0;
    ir3_o  = (complete && ncon > 2) ? ent[3] : '0;
    ncon_o = complete ? ncon : 2'd0;
    occ_o  = count;
    err_orphan_o = err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_n);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count  <= count + CW'(push) - CW'(pop_n);
      err_q  <= orphan;
    end
  end

  // NOTE: the storage array is not reset; count gates every read, so stale words are never seen.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= fi_ir_i;
  end

endmodule

// File: tb/tb_bw_postfix_sequencer.sv
// Bench for bw_postfix_sequencer: queue-level reference model plus a group/orphan scoreboard
// built by parsing the accepted instruction stream; directed scenarios followed by random traffic.
module tb_bw_postfix_sequencer;

  localparam int IW    = 40;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i, fi_valid_i, dr_i;
  logic [IW-1:0] fi_ir_i;
  logic          fi_ready_o, dv_o, err_orphan_o;
  logic [IW-1:0] ir_o, ir1_o, ir2_o, ir3_o;
  logic [1:0]    ncon_o;
  logic [3:0]    occ_o;

  bw_postfix_sequencer #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .fi_valid_i(fi_valid_i), .fi_ir_i(fi_ir_i), .fi_ready_o(fi_ready_o),
    .dv_o(dv_o), .dr_i(dr_i),
    .ir_o(ir_o), .ir1_o(ir1_o), .ir2_o(ir2_o), .ir3_o(ir3_o),
    .ncon_o(ncon_o), .occ_o(occ_o), .err_orphan_o(err_orphan_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit            orphan;
    int            n;
    logic [IW-1:0] w0, w1, w2, w3;
  } ev_t;

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] mq[$];      // words currently held by the queue
  logic [IW-1:0] stream[$];  // accepted words not yet resolved into an event
  ev_t           sb[$];      // expected groups/orphans in order
  bit            exp_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_con(input logic [IW-1:0] w);
    return w[5:0] inside {6'h3D, 6'h3E, 6'h3F};
  endfunction

  function automatic logic [IW-1:0] mk(input logic [5:0] op);
    logic [IW-7:0] r;
    r = (IW-6)'({$urandom(), $urandom()});
    return {r, op};
  endfunction

  function automatic logic [5:0] rand_op();
    if ($urandom_range(0, 99) < 35) return 6'(6'h3D + $urandom_range(0, 2));
    return 6'($urandom_range(0, 6'h3C));
  endfunction

  // Classifies the head of a word list: orphan, complete group of 1+n words, or incomplete.
  function automatic void scan(input logic [IW-1:0] q[$], output bit orph, output bit comp,
                               output int n);
    orph = 0; comp = 0; n = 0;
    if (q.size() == 0) return;
    if (is_con(q[0])) begin orph = 1; return; end
    while (n < 3 && n + 1 < q.size() && is_con(q[n+1])) n++;
    comp = (n == 3) || (n + 1 < q.size());
  endfunction

  function automatic void parse_stream();
    bit o, c; int n; ev_t e;
    forever begin
      scan(stream, o, c, n);
      if (!o && !c) break;
      e.orphan = o; e.n = n;
      e.w0 = stream.pop_front();
      e.w1 = '0; e.w2 = '0; e.w3 = '0;
      if (c && n > 0) e.w1 = stream.pop_front();
      if (c && n > 1) e.w2 = stream.pop_front();
      if (c && n > 2) e.w3 = stream.pop_front();
      sb.push_back(e);
    end
  endfunction

  bit            held = 0;
  logic [IW-1:0] h_ir, h_ir1, h_ir2, h_ir3;
  logic [1:0]    h_ncon;

  // Monitor: checks the cycle's outputs, consumes scoreboard events, then advances the model.
  always @(negedge clk_i) begin : monitor
    bit orph, comp, do_push; int n; ev_t e;
    if (!rst_ni) begin
      mq.delete(); stream.delete(); sb.delete();
      exp_err = 0; held = 0;
    end else begin
      scan(mq, orph, comp, n);
      check("occ", occ_o, mq.size());
      check("fi_ready", fi_ready_o, mq.size() < DEPTH);
      check("err_orphan", err_orphan_o, exp_err);
      check("dv", dv_o, comp);
      if (held) begin
        check("hold_ir", ir_o, h_ir);
        check("hold_ir1", ir1_o, h_ir1);
        check("hold_ir2", ir2_o, h_ir2);
        check("hold_ir3", ir3_o, h_ir3);
        check("hold_ncon", ncon_o, h_ncon);
      end
      if (err_orphan_o) begin
        if (sb.size() == 0) check("sb_orphan_avail", 0, 1);
        else begin
          e = sb.pop_front();
          check("sb_is_orphan", e.orphan, 1);
        end
      end
      if (dv_o && dr_i && !flush_i) begin
        if (sb.size() == 0) check("sb_group_avail", 0, 1);
        else begin
          e = sb.pop_front();
          check("sb_is_group", e.orphan, 0);
          check("grp_ir", ir_o, e.w0);
          check("grp_ir1", ir1_o, e.w1);
          check("grp_ir2", ir2_o, e.w2);
          check("grp_ir3", ir3_o, e.w3);
          check("grp_ncon", ncon_o, e.n);
        end
      end
      held = dv_o && !dr_i && !flush_i;
      h_ir = ir_o; h_ir1 = ir1_o; h_ir2 = ir2_o; h_ir3 = ir3_o; h_ncon = ncon_o;

      do_push = fi_valid_i && (mq.size() < DEPTH) && !flush_i;
      if (flush_i) begin
        mq.delete(); stream.delete(); sb.delete();
        exp_err = 0;
      end else begin
        exp_err = orph;
        if (orph) void'(mq.pop_front());
        else if (comp && dr_i) repeat (1 + n) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back(fi_ir_i);
          stream.push_back(fi_ir_i);
          parse_stream();
        end
      end
    end
  end

  task automatic step(input bit v, input logic [IW-1:0] w, input bit d, input bit f);
    fi_valid_i = v; fi_ir_i = w; dr_i = d; flush_i = f;
    @(posedge clk_i); #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_occ"}, occ_o, 0);
    check({tag, "_dv"}, dv_o, 0);
    check({tag, "_err"}, err_orphan_o, 0);
    check({tag, "_ready"}, fi_ready_o, 1);
    check({tag, "_ir"}, ir_o, 0);
    check({tag, "_ir123"}, {ir1_o, ir2_o, ir3_o}, 0);
    check({tag, "_ncon"}, ncon_o, 0);
  endtask

  logic [IW-1:0] a, b, c1, c2, c3;
  int            pulses;
  bit            dv_seen;

  initial begin
    rst_ni = 1'b0; flush_i = 0; fi_valid_i = 0; dr_i = 0; fi_ir_i = '0;
    @(posedge clk_i); #1;
    reset_checks("rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    a = mk(6'h01); b = mk(6'h02); c1 = mk(6'h3D); c2 = mk(6'h3E); c3 = mk(6'h3F);

    // Plain instruction completed by its follower.
    step(1, a, 0, 0); step(1, b, 0, 0);
    check("t1_dv", dv_o, 1); check("t1_ir", ir_o, a);
    check("t1_ncon", ncon_o, 0); check("t1_ir1", ir1_o, 0);
    check("t1_occ_before", occ_o, 2);
    step(0, '0, 1, 0);
    check("t1_occ_after", occ_o, 1);
    step(0, '0, 0, 1);

    // Two postfixes wait for the next instruction.
    step(1, a, 0, 0); step(1, c1, 0, 0); step(1, c2, 0, 0);
    repeat (3) step(0, '0, 1, 0);
    check("t2_stall_dv", dv_o, 0);
    step(1, b, 0, 0);
    check("t2_dv", dv_o, 1); check("t2_ncon", ncon_o, 2);
    check("t2_ir1", ir1_o, c1); check("t2_ir2", ir2_o, c2); check("t2_ir3", ir3_o, 0);
    check("t2_occ_before", occ_o, 4);
    step(0, '0, 1, 0);
    check("t2_occ_after", occ_o, 1);
    step(0, '0, 0, 1);

    // Three postfixes complete the group with no follower.
    step(1, a, 0, 0); step(1, c1, 0, 0); step(1, c2, 0, 0); step(1, c3, 0, 0);
    check("t3_dv", dv_o, 1); check("t3_ncon", ncon_o, 3); check("t3_ir3", ir3_o, c3);
    step(0, '0, 1, 0);
    check("t3_occ", occ_o, 0);

    // Back-to-back orphans.
    pulses = 0; dv_seen = 0;
    step(1, c2, 1, 0); pulses += int'(err_orphan_o); dv_seen |= dv_o;
    step(1, c1, 1, 0); pulses += int'(err_orphan_o); dv_seen |= dv_o;
    repeat (3) begin
      step(0, '0, 1, 0); pulses += int'(err_orphan_o); dv_seen |= dv_o;
    end
    check("t4_pulses", pulses, 2); check("t4_dv_never", dv_seen, 0);
    check("t4_occ", occ_o, 0);

    // Fill/stall/drain rounds without flush so the pointers wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) step(1, mk(6'($urandom_range(0, 6'h3C))), 0, 0);
      check("t5_full_ready", fi_ready_o, 0);
      repeat (5) step(1, mk(6'h05), 0, 0);
      check("t5_full_occ", occ_o, DEPTH);
      repeat (12) step(0, '0, 1, 0);
      check("t5_drain_occ", occ_o, 1);
    end
    step(0, '0, 0, 1);

    // Flush mid-group with a concurrent push.
    step(1, a, 0, 0); step(1, c1, 0, 0);
    step(1, b, 1, 1);
    check("t6_occ", occ_o, 0); check("t6_dv", dv_o, 0);
    step(0, '0, 1, 0);
    check("t6_occ_later", occ_o, 0);

    // Asynchronous reset mid-group with a concurrent push.
    step(1, a, 0, 0); step(1, c1, 0, 0);
    fi_valid_i = 1; fi_ir_i = b;
    #2 rst_ni = 1'b0;
    #1 reset_checks("arst");
    @(posedge clk_i); #1;
    fi_valid_i = 0;
    rst_ni = 1'b1;
    step(0, '0, 1, 0);
    check("t7_occ", occ_o, 0); check("t7_dv", dv_o, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, mk(rand_op()), $urandom_range(0, 2) != 0,
           $urandom_range(0, 79) == 0);

    // Drain, then terminate the stream so every pending group resolves.
    repeat (20) step(0, '0, 1, 0);
    step(1, mk(6'h07), 1, 0);
    repeat (20) step(0, '0, 1, 0);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
